lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/npc_pkg.sv | 36 +++
 rtl/lsu_if.sv | 46 ++++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu.sv | 112 +++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// ---- npc_pkg: MemOp encodings, LSU state encoding and access legality helper (rev 1.0) ----
`default_nettype none

package npc_pkg;

  typedef enum logic [2:0] {
    MEM_LB  = 3'b000,
    MEM_LH  = 3'b001,
    MEM_LW  = 3'b010,
    MEM_LBU = 3'b100,
    MEM_LHU = 3'b101
  } mem_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Unsigned forms only exist for loads; halves and words must be naturally aligned.
  function automatic logic access_illegal(input logic [2:0] op, input logic wen,
                                          input logic [1:0] lane);
    logic bad;
    case (op)
      MEM_LB:  bad = 1'b0;
      MEM_LBU: bad = wen;
      MEM_LH:  bad = lane[0];
      MEM_LHU: bad = wen | lane[0];
      MEM_LW:  bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_if.sv
// ---- lsu_if: execute-side request, writeback response and data-memory bus of the LSU (rev 1.0) ----
`default_nettype none

interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  // slave: the LSU itself; master: the pipeline and data memory around it
  modport slave (
    input  req_valid, req_wen, req_op, req_addr, req_wdata,
    input  resp_ready,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_wen, req_op, req_addr, req_wdata,
    output resp_ready,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
// ---- lsu_align: store lane mask/replication and load lane extraction with extension (rev 1.0) ----
`default_nettype none

module lsu_align
  import npc_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_fmt
);
  logic [31:0] shifted;
  logic        sign_en;

  // Bring the addressed lane down to bit 0; words are always lane 0 when legal.
  assign shifted = rdata >> {lane, 3'b000};
  assign sign_en = ~op[2];

  always_comb begin
    wmask     = 4'b1111;
    wdata_rep = wdata;
    rdata_fmt = shifted;
    case (op)
      MEM_LB, MEM_LBU: begin
        wmask     = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata_fmt = {{24{shifted[7] & sign_en}}, shifted[7:0]};
      end
      MEM_LH, MEM_LHU: begin
        wmask     = 4'b0011 << lane;
        wdata_rep = {2{wdata[15:0]}};
        rdata_fmt = {{16{shifted[15] & sign_en}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ---- lsu: single-outstanding load/store unit FSM with memory-access timeout (rev 1.0) ----
`default_nettype none

module lsu
  import npc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             wen;
  logic [2:0]       op;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             err;
  logic             expired;
  logic [3:0]       wmask_fmt;
  logic [31:0]      wdata_fmt;
  logic [31:0]      rdata_fmt;

  lsu_align u_align (
    .op        (op),
    .lane      (addr[1:0]),
    .wdata     (wdata),
    .rdata     (bus.mem_rdata),
    .wmask     (wmask_fmt),
    .wdata_rep (wdata_fmt),
    .rdata_fmt (rdata_fmt)
  );

  assign expired = (cnt >= CNT_LAST);

  // Completion events are tested before expiry so a same-cycle handshake wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      wen   <= 1'b0;
      op    <= 3'b000;
      addr  <= 32'h0;
      wdata <= 32'h0;
      rdata <= 32'h0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            wen   <= bus.req_wen;
            op    <= bus.req_op;
            addr  <= bus.req_addr;
            wdata <= bus.req_wdata;
            cnt   <= '0;
            rdata <= 32'h0;
            if (access_illegal(bus.req_op, bus.req_wen, bus.req_addr[1:0])) begin
              err   <= 1'b1;
              state <= ST_RESP;
            end else begin
              err   <= 1'b0;
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (bus.mem_ready) begin
            state <= wen ? ST_RESP : ST_WAIT;
          end else if (expired) begin
            err   <= 1'b1;
            state <= ST_RESP;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (bus.mem_rvalid) begin
            rdata <= rdata_fmt;
            state <= ST_RESP;
          end else if (expired) begin
            err   <= 1'b1;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.mem_valid  = (state == ST_REQ);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_rdata = rdata;
  assign bus.resp_err   = err;
  assign bus.mem_wen    = wen;
  assign bus.mem_addr   = {addr[31:2], 2'b00};
  assign bus.mem_wdata  = wdata_fmt;
  assign bus.mem_wmask  = wen ? wmask_fmt : 4'b0000;

endmodule

`default_nettype wire
